// File: rtl/bids22_bidder_agent.sv
// BIDS22 bidder-lane endpoint: host valid/ready request -> one bid/retract strobe -> ack/timeout -> done pulse.
// Define BIDDER_RETRY_EN to reissue on err=2'b01 or timeout up to MAX_RETRY times.
module bids22_bidder_agent #(
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_retract,
  input  logic [15:0] req_amt,
  output logic        done,
  output logic [1:0]  last_err,
  output logic        timed_out,
  output logic [31:0] balance,
  output logic        won,
  output logic [7:0]  win_count,
  output logic [15:0] bidAmt,
  output logic        bid,
  output logic        retract,
  input  logic        ack,
  input  logic [1:0]  err,
  input  logic [31:0] bal_in,
  input  logic        win_in,
  input  logic        roundOver
);

`ifdef BIDDER_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);
  localparam logic [7:0] TMO_LOAD  = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [2:0]  att_q, att_d;
  logic        rtr_q, rtr_d;
  logic [15:0] amt_q, amt_d;
  logic [1:0]  err_q, err_d;
  logic        to_q, to_d;
  logic [31:0] bal_q, bal_d;
  logic        won_q, won_d;
  logic [7:0]  wins_q, wins_d;
  logic        can_retry;

  assign can_retry = RETRY_EN && (att_q < RETRY_LIM);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    att_d   = att_q;
    rtr_d   = rtr_q;
    amt_d   = amt_q;
    err_d   = err_q;
    to_d    = to_q;
    bal_d   = bal_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        amt_d   = req_retract ? 16'h0000 : req_amt;
        rtr_d   = req_retract;
        att_d   = 3'd0;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        tmo_d   = TMO_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q - 8'd1;
        // An ack on the final count wins over the timeout.
        if (ack) begin
          if (err == 2'b01 && can_retry) begin
            att_d   = att_q + 3'd1;
            state_d = S_DRIVE;
          end else begin
            err_d   = err;
            bal_d   = bal_in;
            to_d    = 1'b0;
            state_d = S_DONE;
          end
        end else if (tmo_q <= 8'd1) begin
          if (can_retry) begin
            att_d   = att_q + 3'd1;
            state_d = S_DRIVE;
          end else begin
            to_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round result tracking runs regardless of the request FSM.
  always_comb begin
    won_d  = roundOver ? win_in : won_q;
    wins_d = wins_q;
    if (roundOver && win_in && wins_q != 8'hFF) wins_d = wins_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      att_q   <= '0;
      rtr_q   <= 1'b0;
      amt_q   <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
      bal_q   <= '0;
      won_q   <= 1'b0;
      wins_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      att_q   <= att_d;
      rtr_q   <= rtr_d;
      amt_q   <= amt_d;
      err_q   <= err_d;
      to_q    <= to_d;
      bal_q   <= bal_d;
      won_q   <= won_d;
      wins_q  <= wins_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign bid       = (state_q == S_DRIVE) && !rtr_q;
  assign retract   = (state_q == S_DRIVE) && rtr_q;
  assign done      = (state_q == S_DONE);
  assign bidAmt    = amt_q;
  assign last_err  = err_q;
  assign timed_out = to_q;
  assign balance   = bal_q;
  assign won       = won_q;
  assign win_count = wins_q;

endmodule

// File: tb/tb_bids22_bidder_agent.sv
// Directed bench for bids22_bidder_agent: bid, retract, timeout, retry, win saturation, reset abort.
module tb_bids22_bidder_agent;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_retract = 1'b0;
  logic [15:0] req_amt = '0;
  logic        ack = 1'b0, win_in = 1'b0, roundOver = 1'b0;
  logic [1:0]  err = '0;
  logic [31:0] bal_in = '0;
  logic        req_ready, done, timed_out, won, bid, retract;
  logic [1:0]  last_err;
  logic [31:0] balance;
  logic [7:0]  win_count;
  logic [15:0] bidAmt;
  int pass_cnt = 0, total = 0;

  bids22_bidder_agent #(.ACK_TIMEOUT(16), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_retract(req_retract), .req_amt(req_amt), .done(done), .last_err(last_err),
    .timed_out(timed_out), .balance(balance), .won(won), .win_count(win_count),
    .bidAmt(bidAmt), .bid(bid), .retract(retract), .ack(ack), .err(err),
    .bal_in(bal_in), .win_in(win_in), .roundOver(roundOver));

  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Issues one request and plays a controller that acks ack_after cycles after each strobe
  // (ack_after < 0 means never). Cycle 0 is the acceptance cycle.
  task automatic do_txn(input logic rt, input logic [15:0] amt, input int ack_after,
                        input logic [1:0] e, input logic [31:0] bal,
                        output int nb, output int nr, output int nd, output int dat,
                        output logic [15:0] amt0, output bit same, output bit rbad);
    int ls = -1000;
    nb = 0; nr = 0; nd = 0; dat = -1; amt0 = 'x; same = 1; rbad = 0;
    req_valid = 1'b1; req_retract = rt; req_amt = amt;
    tick();
    req_valid = 1'b0; req_amt = 16'hDEAD;
    for (int c = 1; c < 100; c++) begin
      if (bid || retract) begin
        if (nb + nr == 0) amt0 = bidAmt;
        else if (bidAmt !== amt0) same = 0;
        ls = c;
      end
      nb += int'(bid); nr += int'(retract);
      if (done) begin nd++; if (dat < 0) dat = c; end
      if (req_ready && dat < 0) rbad = 1;
      ack = (ack_after >= 0 && c == ls + ack_after); err = e; bal_in = bal;
      if (dat >= 0 && c >= dat + 2) break;
      tick();
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else pass_cnt++;
    total++; if ({bid, retract, done} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {bid, retract, done}); else pass_cnt++;
    total++; if ({bidAmt, last_err, timed_out} !== 19'd0) $display("FAIL reset_amt_err got %h/%b/%b want 0", bidAmt, last_err, timed_out); else pass_cnt++;
    total++; if ({balance, won, win_count} !== 41'd0) $display("FAIL reset_bal_win got %h/%b/%0d want 0", balance, won, win_count); else pass_cnt++;
  endtask

  task automatic test_bid();
    int nb, nr, nd, dat; logic [15:0] a0; bit same, rbad;
    do_txn(1'b0, 16'h0100, 3, 2'b00, 32'h0000_0F00, nb, nr, nd, dat, a0, same, rbad);
    total++; if (nb !== 1 || nr !== 0) $display("FAIL bid_strobes got bid=%0d ret=%0d want 1/0", nb, nr); else pass_cnt++;
    total++; if (a0 !== 16'h0100) $display("FAIL bid_amt got %h want 0100", a0); else pass_cnt++;
    total++; if (nd !== 1 || dat !== 5) $display("FAIL bid_done got n=%0d at=%0d want 1 at 5", nd, dat); else pass_cnt++;
    total++; if (balance !== 32'h0F00 || last_err !== 2'b00 || timed_out !== 1'b0)
      $display("FAIL bid_status got %h/%b/%b want 00000f00/00/0", balance, last_err, timed_out); else pass_cnt++;
    total++; if (rbad || req_ready !== 1'b1) $display("FAIL bid_ready got early=%0d now=%b want 0/1", rbad, req_ready); else pass_cnt++;
    total++; if (bidAmt !== 16'h0100) $display("FAIL bid_amt_hold got %h want 0100", bidAmt); else pass_cnt++;
  endtask

  task automatic test_retract();
    int nb, nr, nd, dat; logic [15:0] a0; bit same, rbad;
    do_txn(1'b1, 16'h1234, 2, 2'b11, 32'h0000_ABCD, nb, nr, nd, dat, a0, same, rbad);
    total++; if (nr !== 1 || nb !== 0) $display("FAIL ret_strobes got ret=%0d bid=%0d want 1/0", nr, nb); else pass_cnt++;
    total++; if (a0 !== 16'h0000) $display("FAIL ret_amt got %h want 0000", a0); else pass_cnt++;
    total++; if (last_err !== 2'b11 || balance !== 32'hABCD || nd !== 1 || dat !== 4)
      $display("FAIL ret_status got err=%b bal=%h n=%0d at=%0d want 11/0000abcd/1/4", last_err, balance, nd, dat); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int nb, nr, nd, dat; logic [15:0] a0; bit same, rbad;
    int exp_at;
`ifdef BIDDER_RETRY_EN
    exp_at = 52;
`else
    exp_at = 18;
`endif
    do_txn(1'b0, 16'h0042, -1, 2'b00, 32'hFFFF_FFFF, nb, nr, nd, dat, a0, same, rbad);
    total++; if (nd !== 1 || dat !== exp_at) $display("FAIL tmo_done got n=%0d at=%0d want 1 at %0d", nd, dat, exp_at); else pass_cnt++;
    total++; if (timed_out !== 1'b1) $display("FAIL tmo_flag got %b want 1", timed_out); else pass_cnt++;
    total++; if (balance !== 32'hABCD || last_err !== 2'b11)
      $display("FAIL tmo_keep got bal=%h err=%b want 0000abcd/11", balance, last_err); else pass_cnt++;
  endtask

  task automatic test_retry();
    int nb, nr, nd, dat; logic [15:0] a0; bit same, rbad;
    int exp_nb;
`ifdef BIDDER_RETRY_EN
    exp_nb = 3;
`else
    exp_nb = 1;
`endif
    do_txn(1'b0, 16'h0055, 3, 2'b01, 32'h0000_0077, nb, nr, nd, dat, a0, same, rbad);
    total++; if (nb !== exp_nb) $display("FAIL retry_strobes got %0d want %0d", nb, exp_nb); else pass_cnt++;
    total++; if (!same || a0 !== 16'h0055) $display("FAIL retry_amt got %h same=%0d want 0055/1", a0, same); else pass_cnt++;
    total++; if (nd !== 1 || last_err !== 2'b01 || timed_out !== 1'b0)
      $display("FAIL retry_status got n=%0d err=%b to=%b want 1/01/0", nd, last_err, timed_out); else pass_cnt++;
  endtask

  task automatic test_win_saturate();
    bit saw_done = 0;
    win_in = 1'b1; roundOver = 1'b1;
    for (int k = 0; k < 256; k++) begin
      if (k == 200) begin
        total++; if (win_count !== 8'd200) $display("FAIL win_mid got %0d want 200", win_count); else pass_cnt++;
      end
      if (done) saw_done = 1;
      req_valid = (k == 100); req_amt = 16'h0200; req_retract = 1'b0;
      ack = (k == 102); err = 2'b00; bal_in = 32'h0000_1111;
      tick();
    end
    ack = 1'b0; req_valid = 1'b0; roundOver = 1'b0;
    total++; if (win_count !== 8'd255 || won !== 1'b1) $display("FAIL win_sat got %0d/%b want 255/1", win_count, won); else pass_cnt++;
    total++; if (!saw_done || balance !== 32'h1111 || last_err !== 2'b00)
      $display("FAIL win_ack got done=%0d bal=%h err=%b want 1/00001111/00", saw_done, balance, last_err); else pass_cnt++;
    roundOver = 1'b1; win_in = 1'b0; tick(); roundOver = 1'b0;
    total++; if (won !== 1'b0 || win_count !== 8'd255) $display("FAIL win_lose got %b/%0d want 0/255", won, win_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    req_valid = 1'b1; req_retract = 1'b0; req_amt = 16'h0300; tick();
    req_valid = 1'b0; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (req_ready !== 1'b1 || {bid, retract, done} !== 3'b000)
      $display("FAIL rstmid_ctl got rdy=%b str=%b want 1/000", req_ready, {bid, retract, done}); else pass_cnt++;
    total++; if ({bidAmt, last_err, timed_out, balance, won, win_count} !== 60'd0)
      $display("FAIL rstmid_regs got amt=%h bal=%h wins=%0d want 0", bidAmt, balance, win_count); else pass_cnt++;
    for (int c = 0; c < 20; c++) begin
      ack = 1'b1; if (done || bid || retract) bad = 1; tick();
    end
    ack = 1'b0;
    total++; if (bad) $display("FAIL rstmid_quiet got activity=1 want 0"); else pass_cnt++;
  endtask

  initial begin
    tick();
    test_reset();
    test_bid();
    test_retract();
    test_timeout();
    test_retry();
    test_win_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/bids22_bidder_agent.md
# bids22_bidder_agent

Synthesizable bidder-side endpoint of the BIDS22 bid interface. It drives one bidder lane (`bidAmt`/`bid`/`retract`) toward the bid controller and consumes that lane's responses (`ack`/`err`/`balance`/`win`) plus `roundOver`. A local host issues bid or retract requests through a valid/ready handshake and reads back completion status. One instance sits per bidder lane (X, Y, Z) in the integrated system and in the lane-level bench.

## Interface
- `ACK_TIMEOUT`, 16: cycles to wait for `ack` after the drive cycle (range 1..255).
- `MAX_RETRY`, 2: reissue limit, used only when `BIDDER_RETRY_EN` is defined (range 0..7).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: host request present.
- `req_ready` out 1: agent can accept a request.
- `req_retract` in 1: 1 = retract, 0 = bid.
- `req_amt` in 16: bid amount; ignored for retract.
- `done` out 1: one-cycle completion pulse.
- `last_err` out 2: `err` captured with the final `ack`.
- `timed_out` out 1: final attempt ended with no `ack`.
- `balance` out 32: `bal_in` captured with the last `ack`.
- `won` out 1: `win_in` sampled at the last `roundOver`.
- `win_count` out 8: number of rounds won, saturates at 255.
- `bidAmt` out 16: amount to the controller.
- `bid` out 1: one-cycle bid strobe.
- `retract` out 1: one-cycle retract strobe.
- `ack` in 1, `err` in 2, `bal_in` in 32, `win_in` in 1, `roundOver` in 1: controller responses.

## Operation
- States are IDLE, DRIVE, WAIT and DONE.
- IDLE: `req_ready`=1. When `req_valid`=1, latch `req_amt` and `req_retract`, clear the attempt counter, and go to DRIVE.
- DRIVE (exactly 1 cycle): assert `bid`=!retract_q or `retract`=retract_q. `bidAmt` = latched amount for a bid, 0 for a retract. Load the timeout counter with `ACK_TIMEOUT`, then go to WAIT.
- WAIT: decrement the counter each cycle.
  - On `ack`=1, capture `err` into `last_err` and `bal_in` into `balance`, clear `timed_out`, and go to DONE.
  - If the counter reaches 0 with no `ack`, set `timed_out`=1, leave `last_err` unchanged, and go to DONE.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `bidAmt` holds its value from DRIVE until the next DRIVE.
- `ack` is ignored in every state except WAIT, including the DRIVE cycle.
- Independent of the FSM: on `roundOver`=1, `won`<=`win_in`. If `win_in`=1 and `win_count`<255, increment `win_count`. This works in every state, including alongside an `ack`.

## Timing
- Reset values: state IDLE, `req_ready` 1, `bid`/`retract`/`done` 0, `bidAmt` 0, `last_err` 0, `timed_out` 0, `balance` 0, `won` 0, `win_count` 0.
- Reset asserted mid-transaction aborts it: no `done`, no strobe on the following cycle.
- Latency: request accepted in cycle N, strobe in N+1, earliest `ack` sampled in N+2, `done` in N+3.
- With no `ack`, `done` comes in cycle N+2+`ACK_TIMEOUT`.
- `req_ready` is 0 from the cycle after acceptance until the cycle after `done`. The next request is accepted in the cycle after `done`, giving back-to-back throughput of one transaction per 4 cycles minimum.
- `ack` and `roundOver` in the same cycle: both take effect.
- The `ack` that arrives on the counter's last cycle counts as acked, not as a timeout.
- Counter widths are fixed: the timeout counter is 8 bits and the attempt counter is 3 bits.

## Configuration
- `BIDDER_RETRY_EN` defined: in WAIT, `ack` with `err`=2'b01 (round inactive) or a timeout returns to DRIVE with the same amount, as long as attempts < `MAX_RETRY`. The attempt counter increments on each reissue. `last_err` and `timed_out` reflect only the final attempt, and `done` pulses once per request.
- `BIDDER_RETRY_EN` undefined: no reissue. Every `ack` or timeout goes to DONE, and `MAX_RETRY` is unused.

## Test plan
- Reset, then bid `req_amt`=16'h0100. Controller acks 3 cycles after `bid` with `err`=0 and `bal_in`=32'h0000_0F00. Required: `bid`=1 for exactly 1 cycle with `bidAmt`=16'h0100, `done`=1 once, `balance`=32'h0F00, `last_err`=0, `timed_out`=0.
- Retract request. Required: `retract`=1 for 1 cycle, `bid`=0, `bidAmt`=0. `ack` with `err`=2'b11 gives `last_err`=2'b11.
- No `ack` with `ACK_TIMEOUT`=16. Required: `done` exactly 18 cycles after acceptance, `timed_out`=1, `balance` unchanged.
- With `BIDDER_RETRY_EN` and `MAX_RETRY`=2, controller answers `err`=2'b01 every time. Required: 3 `bid` strobes with identical `bidAmt`, one `done`, `last_err`=2'b01. Without the macro: 1 strobe.
- 256 `roundOver` pulses with `win_in`=1, one of them in the same cycle as an `ack`. Required: `win_count` saturates at 255, `won`=1, and the `ack` is processed normally.
- Assert `reset` during WAIT. Required: all outputs return to reset values, no `done`, `req_ready`=1 on the next cycle.
